// File: rtl/armstrong_pkg.sv
// Shared definitions for the Armstrong range scanner: FSM state codes,
// the decimal radix and width helpers for the digit/power datapath.
package armstrong_pkg;

    localparam int RADIX = 10;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_LOAD  = 4'd1;
    localparam state_t ST_COUNT = 4'd2;
    localparam state_t ST_DIGIT = 4'd3;
    localparam state_t ST_POW   = 4'd4;
    localparam state_t ST_CMP   = 4'd5;
    localparam state_t ST_EMIT  = 4'd6;
    localparam state_t ST_NEXT  = 4'd7;
    localparam state_t ST_FIN   = 4'd8;

    // Number of decimal digits needed for the largest WIDTH-bit value.
    function automatic int digits_of(input int width);
        longint v;
        int     d;
        v = (longint'(1) << width) - 1;
        d = 1;
        while (v >= RADIX) begin
            v = v / RADIX;
            d = d + 1;
        end
        return d;
    endfunction

    // 9**maxdig, the largest single digit power term.
    function automatic longint pow9_of(input int maxdig);
        longint p;
        p = 1;
        for (int i = 0; i < maxdig; i++) p = p * 9;
        return p;
    endfunction

    // Width of one power term.
    function automatic int poww_of(input int maxdig);
        return $clog2(pow9_of(maxdig) + 1);
    endfunction

    // Width of the digit-power sum; maxdig terms of at most 9**maxdig each.
    function automatic int sumw_of(input int maxdig);
        return $clog2(longint'(maxdig) * pow9_of(maxdig) + 1);
    endfunction

endpackage

// File: rtl/armstrong_digit_pow.sv
// Iterative digit power unit: raises a decimal digit to a small exponent
// with one multiply per cycle. A start pulse loads base**1; each following
// cycle multiplies once more. 'last' flags the cycle whose 'prod' is the
// final base**power, so the caller can accumulate it without an extra cycle.
module armstrong_digit_pow
    import armstrong_pkg::*;
#(
    parameter int POWW = 13,
    parameter int NW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      base,
    input  logic [NW-1:0]   power,
    output logic [POWW-1:0] prod,
    output logic            last
);

    logic [POWW-1:0] pow;
    logic [3:0]      base_q;
    logic [NW-1:0]   cnt;

    assign prod = pow * POWW'(base_q);
    assign last = (cnt == NW'(1));

    // Remaining-multiply counter; the only control state in this unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= power - NW'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - NW'(1);
        end
    end

    // Running power and the latched base; data path, not reset.
    always_ff @(posedge clk) begin
        if (start) begin
            pow    <= POWW'(base);
            base_q <= base;
        end else if (cnt != '0) begin
            pow    <= prod;
        end
    end

endmodule

// File: rtl/armstrong_range_scanner.sv
// Sequential Armstrong-number scanner. A start pulse latches [lo, hi]; every
// candidate is checked by counting its digits, then summing digit**n one
// digit at a time through armstrong_digit_pow. Hits leave on a valid/ready
// stream and are counted in a saturating hit counter.
// Optional build macro ARM_SCAN_EARLY_EXIT_EN: abandon a candidate as soon
// as the partial sum exceeds it (same hits, fewer cycles).
module armstrong_range_scanner
    import armstrong_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int MAXDIG = 4,
    parameter int CNTW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [CNTW-1:0]  hit_cnt
);

    localparam int SUMW = sumw_of(MAXDIG);
    localparam int POWW = poww_of(MAXDIG);
    localparam int NW   = $clog2(MAXDIG + 1);
    localparam int CW   = (SUMW > WIDTH) ? SUMW : WIDTH;
    localparam logic [WIDTH-1:0] RADIX_W = WIDTH'(RADIX);

    state_t           state;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [WIDTH-1:0] cand, cand_nxt, tmp, tmp_div;
    logic [3:0]       rem;
    logic [NW-1:0]    n;
    logic [SUMW-1:0]  sum, sum_dig, sum_pow;
    logic             first;
    logic             pw_start, pw_last;
    logic [POWW-1:0]  pw_prod;
    logic             exit_dig, exit_pow;

    assign tmp_div  = tmp / RADIX_W;
    assign rem      = 4'(tmp % RADIX_W);
    assign cand_nxt = first ? lo_q : cand + WIDTH'(1);
    assign sum_dig  = sum + SUMW'(rem);
    assign sum_pow  = sum + SUMW'(pw_prod);
    assign pw_start = (state == ST_DIGIT) && (n != NW'(1));

`ifdef ARM_SCAN_EARLY_EXIT_EN
    assign exit_dig = CW'(sum_dig) > CW'(cand);
    assign exit_pow = CW'(sum_pow) > CW'(cand);
`else
    assign exit_dig = 1'b0;
    assign exit_pow = 1'b0;
`endif

    assign busy      = (state != ST_IDLE) && (state != ST_FIN);
    assign done      = (state == ST_FIN);
    assign out_valid = (state == ST_EMIT);

    armstrong_digit_pow #(
        .POWW (POWW),
        .NW   (NW)
    ) u_pow (
        .clk   (clk),
        .rst   (rst),
        .start (pw_start),
        .base  (rem),
        .power (n),
        .prod  (pw_prod),
        .last  (pw_last)
    );

    // Scan sequencer: walks candidates, drives the digit loop, holds hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            first   <= 1'b0;
            hit_cnt <= '0;
            out_num <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lo_q    <= lo;
                        hi_q    <= hi;
                        hit_cnt <= '0;
                        first   <= 1'b1;
                        state   <= (lo > hi) ? ST_FIN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cand  <= cand_nxt;
                    tmp   <= cand_nxt;
                    n     <= '0;
                    sum   <= '0;
                    first <= 1'b0;
                    state <= ST_COUNT;
                end
                ST_COUNT: begin
                    // A zero candidate still counts as one digit.
                    n <= n + NW'(1);
                    if (tmp_div == '0) begin
                        tmp   <= cand;
                        state <= ST_DIGIT;
                    end else begin
                        tmp   <= tmp_div;
                    end
                end
                ST_DIGIT: begin
                    tmp <= tmp_div;
                    if (n == NW'(1)) begin
                        sum <= sum_dig;
                        if (exit_dig)
                            state <= ST_NEXT;
                        else
                            state <= (tmp_div != '0) ? ST_DIGIT : ST_CMP;
                    end else begin
                        state <= ST_POW;
                    end
                end
                ST_POW: begin
                    if (pw_last) begin
                        sum <= sum_pow;
                        if (exit_pow)
                            state <= ST_NEXT;
                        else
                            state <= (tmp != '0) ? ST_DIGIT : ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (CW'(sum) == CW'(cand)) begin
                        out_num <= cand;
                        state   <= ST_EMIT;
                    end else begin
                        state   <= ST_NEXT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNTW'(1);
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Stop on hi before incrementing so the candidate never wraps.
                    state <= (cand == hi_q) ? ST_FIN : ST_LOAD;
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_armstrong_range_scanner.sv
// Bench for armstrong_range_scanner: directed and random range scans with
// random/stalled consumer back-pressure, compared against an arithmetic
// Armstrong reference model.
module tb_armstrong_range_scanner;

    localparam int WIDTH  = 10;
    localparam int MAXDIG = 4;
    localparam int CNTW   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] lo, hi;
    logic             busy, done, out_valid, out_ready;
    logic [WIDTH-1:0] out_num;
    logic [CNTW-1:0]  hit_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    armstrong_range_scanner #(
        .WIDTH  (WIDTH),
        .MAXDIG (MAXDIG),
        .CNTW   (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .hit_cnt   (hit_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum of each decimal digit raised to the digit count.
    function automatic bit is_arm(input int v);
        int d, t, s, p, r;
        if (v == 0) return 1'b1;
        d = 0;
        t = v;
        while (t > 0) begin d++; t = t / 10; end
        s = 0;
        t = v;
        while (t > 0) begin
            r = t % 10;
            p = 1;
            for (int k = 0; k < d; k++) p = p * r;
            s = s + p;
            t = t / 10;
        end
        return s == v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: random ready, 2: hold ready low 20 cycles per hit.
    task automatic run_scan(input int l, input int h, input int mode,
                            input bit poke_start, output int done_k);
        int  exp_q[$];
        int  got[$];
        int  budget, k, stall, prev, cap;
        bit  seen_done, pend, rdy;
        for (int v = l; v <= h; v++) if (is_arm(v)) exp_q.push_back(v);
        budget    = ((h >= l) ? (h - l + 1) : 0) * 40 + exp_q.size() * 100 + 200;
        seen_done = 1'b0;
        pend      = 1'b0;
        prev      = -1;
        stall     = 0;
        done_k    = -1;
        k         = 0;
        out_ready = (mode == 0);
        lo        = WIDTH'(l);
        hi        = WIDTH'(h);
        start     = 1'b1;
        step();
        start     = 1'b0;
        while (!seen_done && k < budget) begin
            if (poke_start) begin
                start = (k == 5);
                if (k == 5) begin lo = '0; hi = 10'd9; end
            end
            if (done) begin
                seen_done = 1'b1;
                done_k    = k;
            end
            check("busy_vs_done", int'(busy), int'(!done));
            if (out_valid) begin
                if (pend) check("num_stable", int'(out_num), prev);
                check("hit_cnt_live", int'(hit_cnt), got.size());
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = (stall >= 20);
                endcase
                out_ready = rdy;
                if (rdy) begin
                    got.push_back(int'(out_num));
                    pend  = 1'b0;
                    stall = 0;
                end else begin
                    pend  = 1'b1;
                    prev  = int'(out_num);
                    stall++;
                end
            end else begin
                if (pend) check("valid_held", 0, 1);
                pend      = 1'b0;
                out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            step();
            k++;
        end
        start = 1'b0;
        check("done_seen", int'(seen_done), 1);
        check("done_one_pulse", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("hit_count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check("hit_val", got[i], exp_q[i]);
        cap = (exp_q.size() > 255) ? 255 : exp_q.size();
        check("hit_cnt_final", int'(hit_cnt), cap);
        out_ready = 1'b1;
    endtask

    initial begin
        int dk, l, h, k;
        rst       = 1'b1;
        start     = 1'b0;
        lo        = '0;
        hi        = '0;
        out_ready = 1'b1;
        step(); step(); step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_num", int'(out_num), 0);
        check("rst_hits", int'(hit_cnt), 0);
        rst = 1'b0;
        step();

        run_scan(0, 9, 0, 1'b0, dk);
        run_scan(100, 999, 1, 1'b0, dk);
        run_scan(5, 3, 0, 1'b0, dk);
        check("empty_done_fast", int'(dk >= 0 && dk <= 1), 1);
        run_scan(150, 160, 2, 1'b0, dk);
        run_scan(1000, 1023, 1, 1'b0, dk);
        run_scan(1023, 1023, 0, 1'b0, dk);

`ifndef ARM_SCAN_EARLY_EXIT_EN
        run_scan(154, 154, 0, 1'b0, dk);
        check("latency_154", dk, 15);
        run_scan(153, 153, 0, 1'b0, dk);
        check("latency_153", dk, 16);
`endif

        // Reset in the middle of a scan with a hit pending on the stream.
        out_ready = 1'b0;
        lo        = 10'd100;
        hi        = 10'd999;
        start     = 1'b1;
        step();
        start     = 1'b0;
        k         = 0;
        while (!out_valid && k < 3000) begin step(); k++; end
        check("mid_hit_seen", int'(out_valid), 1);
        step(); step(); step();
        rst = 1'b1;
        step();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_num", int'(out_num), 0);
        check("mid_rst_hits", int'(hit_cnt), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        step(); step();
        check("post_rst_idle", int'(busy | out_valid | done), 0);

        run_scan(100, 999, 1, 1'b1, dk);

        for (int i = 0; i < 6; i++) begin
            l = int'($urandom_range(0, 1023));
            if (i == 5) h = l - 1;
            else begin
                h = l + int'($urandom_range(0, 40));
                if (h > 1023) h = 1023;
            end
            run_scan(l, h, 1, 1'b0, dk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
